// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and PC sequencer state encoding
package cpu_pkg;

    localparam int ADDR_W = 32;
    localparam int OFF_W  = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [OFF_W-1:0]  PC_INC_DEF   = 16'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_RESOLVE,
        ST_NEXT
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch, decode and retire handshakes of the PC sequencer
interface pc_sequencer_if;
    import cpu_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic              ret_valid;
    logic              br_taken;
    logic [OFF_W-1:0]  br_offset;

    modport master (
        output imem_req, imem_addr, instr_valid, instr,
        input  imem_ack, imem_rdata, instr_ready, ret_valid, br_taken, br_offset
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr,
        output imem_ack, imem_rdata, instr_ready, ret_valid, br_taken, br_offset
    );

endinterface

// File: rtl/pc_sequencer_adder.sv
// rtl/pc_sequencer_adder.sv - shared 32+16-bit address adder, carry out discarded
module adder
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] a,
    input  logic [OFF_W-1:0]  b,
    output logic [ADDR_W-1:0] sum
);

    assign sum = a + {{(ADDR_W-OFF_W){1'b0}}, b};

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle PC sequencer: fetch, issue, wait retire, advance pc
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [OFF_W-1:0]  PC_INC   = PC_INC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] pc,
    pc_sequencer_if.master    bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              br_taken_q, br_taken_d;
    logic [OFF_W-1:0]  br_offset_q, br_offset_d;
    logic              imem_req_q, imem_req_d;
    logic              instr_valid_q, instr_valid_d;
    logic [OFF_W-1:0]  add_op2;
    logic [ADDR_W-1:0] add_sum;

    // The single adder serves both sequential increment and branch target.
    assign add_op2 = br_taken_q ? br_offset_q : PC_INC;

    adder u_adder (
        .a   (pc_q),
        .b   (add_op2),
        .sum (add_sum)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        br_taken_d  = br_taken_q;
        br_offset_d = br_offset_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.instr_ready) state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                if (bus.ret_valid) begin
                    br_taken_d  = bus.br_taken;
                    br_offset_d = bus.br_offset;
                    state_d     = ST_NEXT;
                end
            end
            ST_NEXT: begin
                pc_d    = add_sum;
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake outputs come from the next state so they are pure flops.
        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            br_taken_q    <= 1'b0;
            br_offset_q   <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            br_taken_q    <= br_taken_d;
            br_offset_q   <= br_offset_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign pc              = pc_q;
    assign bus.imem_addr   = pc_q;
    assign bus.imem_req    = imem_req_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter sequencer for the single-issue CPU. It owns the PC register and drives the instruction-memory fetch handshake. It hands each fetched word to decode and waits for execute to retire the instruction. It then time-shares the CPU's single 32+16-bit address adder between sequential increment (PC + 4) and branch-target generation (PC + offset).

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_INC, 16'd4, sequential increment fed to the adder's 16-bit operand

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- run  in  1  level; leaves IDLE when high
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  memory accepted request; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr is valid for decode
- instr  out  32  registered instruction word
- instr_ready  in  1  decode accepts instr
- ret_valid  in  1  execute retires the in-flight instruction (one-cycle pulse)
- br_taken  in  1  qualified by ret_valid; retiring instruction is a taken branch
- br_offset  in  16  qualified by ret_valid; unsigned byte offset
- pc  out  32  current PC (address of in-flight instruction)

## Operation
- FSM states:
  - IDLE: run=1 -> FETCH.
  - FETCH: imem_req=1. On imem_ack, latch imem_rdata into instr -> ISSUE.
  - ISSUE: instr_valid=1. On instr_ready -> RESOLVE.
  - RESOLVE: wait for ret_valid. Latch br_taken/br_offset -> NEXT.
  - NEXT: adder operand2 = br_taken_q ? br_offset_q : PC_INC. Load pc with the adder result. run=1 -> FETCH, else -> IDLE.
- Adder: 32-bit operand = pc, 16-bit operand zero-extended, sum modulo 2^32. Backward branches are not supported. Carry out is discarded: pc 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- br_offset low bits are not checked. A misaligned target is passed to imem_addr unchanged.
- ret_valid outside RESOLVE is ignored; br_taken/br_offset are then don't-care.
- imem_ack outside FETCH is ignored. imem_rdata is sampled only on imem_ack in FETCH.
- Exactly one instruction in flight; no speculation or prefetch.
- Reset from any state, mid-handshake included: next edge forces IDLE, pc=RESET_PC, instr=0, latched branch info cleared. The pending memory request is abandoned, and the memory side must tolerate req dropping.

## Timing
- Reset values: imem_req=0, instr_valid=0, instr=32'h0, pc=imem_addr=RESET_PC.
- imem_req and instr_valid are decoded from registered state: no combinational path from imem_ack/instr_ready.
- imem_ack in the first FETCH cycle gives a one-cycle FETCH. ISSUE and RESOLVE are likewise one cycle minimum.
- Minimum instruction period is 4 cycles (FETCH, ISSUE, RESOLVE, NEXT). Each wait cycle on ack/ready/ret_valid adds one.
- New pc is visible the cycle after NEXT, coincident with imem_req rising (FETCH) or IDLE.
- run is sampled only in IDLE and NEXT. Dropping run mid-instruction completes the current instruction, then idles.
- imem_req stays high and imem_addr stable from FETCH entry until imem_ack.
- instr_valid stays high and instr stable from ISSUE entry until instr_ready.

## Structure
- Shared package cpu_pkg holds:
  - state encoding (IDLE, FETCH, ISSUE, RESOLVE, NEXT)
  - RESET_PC default
  - PC_INC constant
  - width constants ADDR_W=32, OFF_W=16
- One sub-module, the existing `adder` (32-bit + 16-bit), instantiated once. Its operand2 mux sits in pc_sequencer. No second adder is permitted.

## Test plan
- Reset/idle: assert rst_n=0 mid-FETCH with imem_req high. Next edge: imem_req=0, instr_valid=0, pc=0. Keep run=0 and confirm pc holds at 0 for 10 cycles.
- Sequential run: run=1, imem_ack/instr_ready/ret_valid immediate, br_taken=0, imem_rdata = 0x11111111, 0x22222222, 0x33333333. Expect:
  - imem_addr 0x0, 0x4, 0x8, one fetch every 4 cycles
  - instr words match in order
- Taken branch: at pc=0x100, retire with br_taken=1, br_offset=0x0040. Expect next imem_addr=0x140. Then retire with br_taken=0 and expect 0x144.
- Handshake stalls: imem_ack delayed 3 cycles, instr_ready delayed 2, ret_valid delayed 5. Expect imem_addr/instr stable throughout and period 4+10=14 cycles. A spurious ret_valid during ISSUE must not advance pc.
- Wrap: RESET_PC=32'hFFFF_FFFC, br_taken=0. Second fetch address = 32'h0000_0000. With br_offset=0xFFFF from pc=0xFFFF_0004, target = 0x0000_0003.
- Run drop: deassert run during RESOLVE. The instruction retires, pc advances by 4, FSM reaches IDLE with imem_req=0. Reassert run and the fetch occurs at the advanced pc.
